// File: rtl/exec_monitor.sv
// Run monitor for the multicycle RV64 core.
// Classifies fetched instructions, counts them, and flags halt or watchdog expiry.
module exec_monitor #(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned PC_W        = 64,
   parameter int unsigned TIMEOUT_CYC = 10000,
   parameter logic [31:0] HALT_INSTR  = 32'h0000006F,
   parameter int unsigned HALT_REPEAT = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             instr_valid,
   input  logic [31:0]      instr,
   input  logic [PC_W-1:0]  pc,
   input  logic [2:0]       rd_sel,
   output logic [CNT_W-1:0] rd_count,
   output logic [CNT_W-1:0] instr_count,
   output logic [CNT_W-1:0] cycle_count,
   output logic             running,
   output logic             halted,
   output logic             timeout
);

   localparam int REP_W = $clog2(HALT_REPEAT) + 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HLT,
      TMO
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cls_cnt [8];
   logic [PC_W-1:0]  last_pc;
   logic [REP_W-1:0] rep_cnt;
   logic [2:0]       cls;
   logic             accept;
   logic             same_pc;
   logic             halt_hit;
   logic             wd_hit;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // opcode -> instruction class
   always_comb begin
      cls = 3'd7;
      case (instr[6:0])
         7'b0110011: cls = 3'd0;
         7'b0010011: cls = 3'd1;
         7'b0000011: cls = 3'd2;
         7'b0100011: cls = 3'd3;
         7'b1100011: cls = 3'd4;
         7'b0110111,
         7'b0010111: cls = 3'd5;
         7'b1101111,
         7'b1100111: cls = 3'd6;
         default:    cls = 3'd7;
      endcase
   end

   // fetch acceptance, halt detection and watchdog compare
   always_comb begin
      accept   = instr_valid && (state == IDLE || state == RUN);
      same_pc  = (pc == last_pc);
      halt_hit = instr_valid && (state == RUN) &&
                 ((instr == HALT_INSTR) ||
                  (same_pc && rep_cnt == REP_W'(HALT_REPEAT - 2)));
      wd_hit   = (TIMEOUT_CYC != 0) && (state == RUN) &&
                 (64'(cycle_count) == 64'(TIMEOUT_CYC) - 64'd1);
   end

   assign rd_count = cls_cnt[rd_sel];

   // run-state FSM with registered status flags; halt beats watchdog
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         running <= 1'b0;
         halted  <= 1'b0;
         timeout <= 1'b0;
      end else if (clear) begin
         state   <= IDLE;
         running <= 1'b0;
         halted  <= 1'b0;
         timeout <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (instr_valid) begin
               state   <= RUN;
               running <= 1'b1;
            end
            RUN: if (halt_hit) begin
               state   <= HLT;
               running <= 1'b0;
               halted  <= 1'b1;
            end else if (wd_hit) begin
               state   <= TMO;
               running <= 1'b0;
               timeout <= 1'b1;
            end
            HLT: state <= HLT;
            TMO: state <= TMO;
         endcase
      end
   end

   // saturating counters and repeat-PC tracking
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) cls_cnt[i] <= '0;
         instr_count <= '0;
         cycle_count <= '0;
         last_pc     <= '0;
         rep_cnt     <= '0;
      end else if (clear) begin
         for (int i = 0; i < 8; i++) cls_cnt[i] <= '0;
         instr_count <= '0;
         cycle_count <= '0;
         last_pc     <= '0;
         rep_cnt     <= '0;
      end else begin
         if (state == RUN) cycle_count <= sat_inc(cycle_count);
         if (accept) begin
            cls_cnt[cls] <= sat_inc(cls_cnt[cls]);
            instr_count  <= sat_inc(instr_count);
            last_pc      <= pc;
            if (!same_pc)      rep_cnt <= '0;
            else if (~&rep_cnt) rep_cnt <= rep_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_exec_monitor.sv
// Bench for exec_monitor: directed programs plus random fetch streams
// against a fetch-level reference model.
module tb_exec_monitor;

   localparam int          TO   = 20;
   localparam logic [31:0] HALT = 32'h0000006F;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear;
   logic        instr_valid;
   logic [31:0] instr;
   logic [63:0] pc;
   logic [2:0]  rd_sel;
   logic [31:0] rd_count, instr_count, cycle_count;
   logic        running, halted, timeout;
   logic [3:0]  rd4, ic4, cc4;
   logic        run4, halt4, to4;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   longint      m_cls [8];
   longint      m_total;
   longint      m_cyc;
   bit          m_run, m_halt, m_to;
   logic [63:0] m_last;
   int          m_streak;

   logic [6:0] opc_tab [12] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                7'b0100011, 7'b1100011, 7'b0110111,
                                7'b0010111, 7'b1101111, 7'b1100111,
                                7'b0011011, 7'b0111011, 7'b1110011};
   int cls_tab [12] = '{0, 1, 2, 3, 4, 5, 5, 6, 6, 7, 7, 7};

   exec_monitor #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset(reset), .clear(clear),
      .instr_valid(instr_valid), .instr(instr), .pc(pc),
      .rd_sel(rd_sel), .rd_count(rd_count),
      .instr_count(instr_count), .cycle_count(cycle_count),
      .running(running), .halted(halted), .timeout(timeout)
   );

   exec_monitor #(.CNT_W(4), .TIMEOUT_CYC(0)) dut4 (
      .clk(clk), .reset(reset), .clear(clear),
      .instr_valid(instr_valid), .instr(instr), .pc(pc),
      .rd_sel(rd_sel), .rd_count(rd4),
      .instr_count(ic4), .cycle_count(cc4),
      .running(run4), .halted(halt4), .timeout(to4)
   );

   always #5 clk = ~clk;

   function automatic int class_of(input logic [31:0] ins);
      for (int i = 0; i < 12; i++)
         if (ins[6:0] == opc_tab[i]) return cls_tab[i];
      return 7;
   endfunction

   function automatic longint sat32(input longint x);
      return (x > 64'd4294967295) ? 64'd4294967295 : x;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_cls[i] = 0;
      m_total  = 0;
      m_cyc    = 0;
      m_run    = 0;
      m_halt   = 0;
      m_to     = 0;
      m_last   = '0;
      m_streak = 1;
   endtask

   // one clock edge of the monitor, described at the fetch level
   task automatic model_edge(input bit v, input logic [31:0] ins,
                             input logic [63:0] p, input bit clr);
      bit live, spin, wd;
      if (clr) begin
         model_reset();
         return;
      end
      live = !m_halt && !m_to;
      spin = v && m_run &&
             (ins == HALT || (p == m_last && m_streak >= 2));
      wd   = m_run && (m_cyc == TO - 1);
      if (m_run) m_cyc = sat32(m_cyc + 1);
      if (v && live) begin
         m_cls[class_of(ins)] = sat32(m_cls[class_of(ins)] + 1);
         m_total  = sat32(m_total + 1);
         m_streak = (p == m_last) ? m_streak + 1 : 1;
         m_last   = p;
      end
      if (m_run && spin) begin
         m_run  = 0;
         m_halt = 1;
      end else if (wd) begin
         m_run = 0;
         m_to  = 1;
      end else if (live && !m_run && v) begin
         m_run = 1;
      end
   endtask

   task automatic compare_all();
      rd_sel = 3'($urandom_range(0, 7));
      #1;
      chk("rd_count", rd_count, m_cls[rd_sel]);
      chk("instr_count", instr_count, m_total);
      chk("cycle_count", cycle_count, m_cyc);
      chk("running", running, m_run);
      chk("halted", halted, m_halt);
      chk("timeout", timeout, m_to);
   endtask

   task automatic step(input bit v, input logic [31:0] ins,
                       input logic [63:0] p, input bit clr);
      instr_valid = v;
      instr       = ins;
      pc          = p;
      clear       = clr;
      @(posedge clk);
      model_edge(v, ins, p, clr);
      #1;
      instr_valid = 1'b0;
      clear       = 1'b0;
      compare_all();
   endtask

   task automatic pulse_reset();
      #1 reset = 1'b1;
      #1 reset = 1'b0;
      model_reset();
   endtask

   task automatic read_cls(input int s, output logic [31:0] v);
      rd_sel = 3'(s);
      #1 v = rd_count;
   endtask

   logic [31:0] rv;
   logic [31:0] rnd;
   logic [63:0] cur_pc;
   logic [31:0] rins;
   logic [63:0] rpc;
   bit          rvld, rclr;
   int          nstep;
   int          icnt_to;

   initial begin
      reset = 1'b1; clear = 1'b0; instr_valid = 1'b0;
      instr = '0; pc = '0; rd_sel = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_instr_count", instr_count, 0);
      chk("rst_cycle_count", cycle_count, 0);
      chk("rst_flags", {running, halted, timeout}, 0);
      chk("rst_rd_count", rd_count, 0);

      // R-type program ending in the halt word
      step(1, 32'h003100B3, 64'h0, 0);
      step(1, 32'h403100B3, 64'h4, 0);
      step(1, 32'h003100B3, 64'h8, 0);
      step(1, 32'h403100B3, 64'hC, 0);
      step(1, HALT, 64'h10, 0);
      step(0, 32'h0, 64'h0, 0);
      read_cls(0, rv); chk("rtype_class0", rv, 4);
      read_cls(6, rv); chk("rtype_class6", rv, 1);
      chk("rtype_total", instr_count, 5);
      chk("rtype_halted", halted, 1);

      // loads / stores ending in jal x0,0
      pulse_reset();
      step(1, 32'h0000B083, 64'h0, 0);
      step(1, 32'h0000B083, 64'h4, 0);
      step(1, 32'h00108093, 64'h8, 0);
      step(1, 32'h0010B023, 64'hC, 0);
      step(1, HALT, 64'h10, 0);
      read_cls(2, rv); chk("ld_class2", rv, 2);
      read_cls(1, rv); chk("ld_class1", rv, 1);
      read_cls(3, rv); chk("ld_class3", rv, 1);
      chk("ld_halted", halted, 1);

      // PC spin on beq x0,x0,0
      step(0, 32'h0, 64'h0, 1);
      step(1, 32'h00000063, 64'h20, 0);
      step(1, 32'h00000063, 64'h20, 0);
      chk("spin_not_yet", halted, 0);
      step(1, 32'h00000063, 64'h20, 0);
      chk("spin_halted", halted, 1);
      read_cls(4, rv); chk("spin_class4", rv, 3);

      // watchdog: one fetch every 4 cycles, no halt
      step(0, 32'h0, 64'h0, 1);
      for (int i = 0; i < 30; i++) begin
         step(i % 4 == 0, 32'h00108093, 64'h200 + 64'(4 * i), 0);
         if (i == 19) chk("wd_pre", timeout, 0);
         if (i == 20) icnt_to = int'(instr_count);
      end
      chk("wd_timeout", timeout, 1);
      chk("wd_cycles", cycle_count, TO);
      chk("wd_frozen", instr_count, 6);
      chk("wd_frozen2", instr_count, icnt_to);

      // 4-bit counters saturate
      pulse_reset();
      for (int i = 0; i < 20; i++)
         step(1, 32'h00108093, 64'h1000 + 64'(4 * i), 0);
      rd_sel = 3'd1;
      #1;
      chk("sat_class1", rd4, 15);
      chk("sat_total", ic4, 15);
      chk("sat_wide_total", instr_count, 20);

      // clear wins over a same-edge fetch
      pulse_reset();
      step(1, 32'h00108093, 64'h300, 0);
      step(1, 32'h00108093, 64'h304, 0);
      step(1, 32'h00108093, 64'h308, 1);
      chk("clr_total", instr_count, 0);
      chk("clr_cycles", cycle_count, 0);
      chk("clr_running", running, 0);

      // async reset between edges
      step(1, 32'h00108093, 64'h400, 0);
      step(1, 32'h003100B3, 64'h404, 0);
      step(1, 32'h0000B083, 64'h408, 0);
      #1 reset = 1'b1;
      #1;
      chk("arst_total", instr_count, 0);
      chk("arst_cycles", cycle_count, 0);
      chk("arst_running", running, 0);
      reset = 1'b0;
      model_reset();

      // random fetch streams
      cur_pc = 64'h100;
      for (int b = 0; b < 12; b++) begin
         step(0, 32'h0, 64'h0, 1);
         nstep = $urandom_range(15, 40);
         for (int k = 0; k < nstep; k++) begin
            rvld = ($urandom_range(0, 9) < 6);
            rclr = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) < 3) rpc = cur_pc;
            else rpc = 64'h100 + 64'(4 * $urandom_range(0, 7));
            rnd = $urandom();
            if ($urandom_range(0, 19) == 0) rins = HALT;
            else rins = {rnd[31:7], opc_tab[$urandom_range(0, 11)]};
            if (rvld) cur_pc = rpc;
            step(rvld, rins, rpc, rclr);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
